// File: rtl/kong_pkg.sv
// kong_pkg: shared keypad constants, key index type and lowest-set-key encoder
package kong_pkg;
   typedef logic [3:0] key_index;
   localparam key_index KEY_UP    = 4'd1;
   localparam key_index KEY_LEFT  = 4'd4;
   localparam key_index KEY_JUMP  = 4'd5;
   localparam key_index KEY_RIGHT = 4'd6;
   localparam key_index KEY_DOWN  = 4'd9;
   function automatic key_index first_key(input logic [15:0] v);
      first_key = '0;
      for (int i = 15; i >= 0; i--)
         if (v[i]) first_key = key_index'(i);
   endfunction
endpackage

// File: rtl/kong_key_debounce.sv
// kong_key_debounce: per-key scan-count debouncer holding one stable bit
// Ports: clk, resetN (async active-low), scan_done (one-cycle scan strobe),
//        raw (latest sampled key level), stable (debounced key level)
module kong_key_debounce #(
   parameter int DEBOUNCE_SCANS = 8
) (
   input  logic clk,
   input  logic resetN,
   input  logic scan_done,
   input  logic raw,
   output logic stable
);
   logic [7:0] r_cnt;
   logic       r_stable;
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else if (scan_done) begin
         if (raw == r_stable) r_cnt <= '0;
         else if (r_cnt == 8'(DEBOUNCE_SCANS - 1)) begin
            r_stable <= raw;
            r_cnt    <= '0;
         end else r_cnt <= r_cnt + 8'd1;
      end
   end
   assign stable = r_stable;
endmodule

// File: rtl/kong_keypad_scanner.sv
// kong_keypad_scanner: 4x4 keypad column scanner with per-key debounce and movement requests
// Ports: clk, resetN (async active-low), row_n (active-low rows, async),
//        col_n (one-low column drive), ask_move_* (debounced move levels),
//        key_pressed (any key down), key_code (lowest pressed key index)
module kong_keypad_scanner
   import kong_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 8
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic       ask_move_up,
   output logic       ask_move_left,
   output logic       ask_move_jump,
   output logic       ask_move_right,
   output logic       ask_move_down,
   output logic       key_pressed,
   output logic [3:0] key_code
);
   localparam int CW = $clog2(SCAN_DIV);
   logic [3:0]    r_sync1, r_sync2;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_col;
   logic [15:0]   r_raw;
   logic          r_scan_done;
   logic [4:0]    r_ask;
   logic          r_pressed;
   key_index      r_code;
   logic [15:0]   w_stable, w_key;
   logic          w_dwell_end;
   assign w_dwell_end = r_cnt == CW'(SCAN_DIV - 1);
   assign col_n       = ~(4'b0001 << r_col);
   // raw is column-major (col*4+row); rows are sampled at dwell end so the
   // synchronizer and the keypad lines have settled for the active column
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_sync1     <= 4'hF;
         r_sync2     <= 4'hF;
         r_cnt       <= '0;
         r_col       <= '0;
         r_raw       <= '0;
         r_scan_done <= 1'b0;
      end else begin
         r_sync1     <= row_n;
         r_sync2     <= r_sync1;
         r_scan_done <= w_dwell_end && r_col == 2'd3;
         r_cnt       <= w_dwell_end ? '0 : r_cnt + CW'(1);
         if (w_dwell_end) begin
            r_raw[{r_col, 2'b00} +: 4] <= ~r_sync2;
            r_col                      <= r_col + 2'd1;
         end
      end
   end
   for (genvar k = 0; k < 16; k++) begin : g_deb
      kong_key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb (
         .clk       (clk),
         .resetN    (resetN),
         .scan_done (r_scan_done),
         .raw       (r_raw[k]),
         .stable    (w_stable[k])
      );
   end
   // transpose to row-major key index (row*4+col)
   always_comb begin
      w_key = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            w_key[r*4+c] = w_stable[c*4+r];
   end
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_ask     <= '0;
         r_pressed <= 1'b0;
         r_code    <= '0;
      end else begin
         r_ask     <= {w_key[KEY_UP], w_key[KEY_LEFT], w_key[KEY_JUMP], w_key[KEY_RIGHT], w_key[KEY_DOWN]};
         r_pressed <= |w_key;
         r_code    <= first_key(w_key);
      end
   end
   assign {ask_move_up, ask_move_left, ask_move_jump, ask_move_right, ask_move_down} = r_ask;
   assign key_pressed = r_pressed;
   assign key_code    = r_code;
endmodule

// File: tb/tb_kong_keypad_scanner.sv
// tb_kong_keypad_scanner: scoreboard bench for the keypad scanner with a modelled keypad
module tb_kong_keypad_scanner;
   logic       clk = 1'b0;
   logic       resetN;
   logic [3:0] row_n, col_n;
   logic       ask_move_up, ask_move_left, ask_move_jump, ask_move_right, ask_move_down;
   logic       key_pressed;
   logic [3:0] key_code;
   logic [15:0] keys;
   logic [9:0]  out_v;
   typedef struct {logic [9:0] v; int w;} exp_t;
   exp_t q[$];
   int total = 0, bad = 0, cyc = 0, wraps = 0, wrap_cyc = 0;
   logic [3:0] prev_col = 4'b1110;
   logic [9:0] prev_out = '0;
   kong_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .clk(clk), .resetN(resetN), .row_n(row_n), .col_n(col_n),
      .ask_move_up(ask_move_up), .ask_move_left(ask_move_left), .ask_move_jump(ask_move_jump),
      .ask_move_right(ask_move_right), .ask_move_down(ask_move_down),
      .key_pressed(key_pressed), .key_code(key_code)
   );
   always #5 clk = ~clk;
   // keypad: a row reads low when a held key sits on it in the driven column
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
   end
   assign out_v = {ask_move_up, ask_move_left, ask_move_jump, ask_move_right, ask_move_down, key_pressed, key_code};
   function automatic logic [9:0] mk(input logic u, l, j, r, d, kp, input logic [3:0] code);
      return {u, l, j, r, d, kp, code};
   endfunction
   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
      end
   endtask
   task automatic push(input logic [9:0] v, input int w);
      exp_t e;
      e.v = v;
      e.w = w;
      q.push_back(e);
   endtask
   task automatic finish_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask
   task automatic next_wrap();
      int w0, g;
      w0 = wraps;
      g  = 0;
      do begin
         @(negedge clk);
         #1;
         g++;
      end while (wraps == w0 && g < 100);
      if (wraps == w0) begin
         chk("wrap_timeout", wraps, w0 + 1);
         finish_run();
      end
   endtask
   task automatic wait_to(input int t);
      while (wraps < t) next_wrap();
   endtask
   // monitor: counts scan wraps (col_n 0111->1110) and checks every output change
   initial forever begin
      exp_t e;
      @(negedge clk);
      cyc++;
      if (prev_col == 4'b0111 && col_n == 4'b1110) begin
         wraps++;
         wrap_cyc = cyc;
      end
      prev_col = col_n;
      if (!resetN) prev_out = out_v;
      else if (out_v != prev_out) begin
         if (q.size() == 0) chk("unexpected_change", int'(out_v), int'(prev_out));
         else begin
            e = q.pop_front();
            chk("out_value", int'(out_v), int'(e.v));
            chk("out_scan", wraps, e.w);
            chk("out_delay", cyc - wrap_cyc, 2);
         end
         prev_out = out_v;
      end
   end
   initial begin
      logic [3:0] cs [5];
      int w;
      cs = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      keys   = '0;
      resetN = 1'b1;
      #2 resetN = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_col_n", int'(col_n), 4'b1110);
      chk("reset_outputs", int'(out_v), 0);
      @(negedge clk);
      resetN = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("col_seq%0d", i), int'(col_n), int'(cs[i]));
         repeat (4) @(negedge clk);
      end
      // jump press and release
      next_wrap();
      w = wraps;
      keys = 16'h1 << 5;
      push(mk(0, 0, 1, 0, 0, 1, 4'd5), w + 3);
      wait_to(w + 4);
      keys = '0;
      push('0, w + 7);
      wait_to(w + 8);
      // bounce on key 6: 2 present, 1 absent, then steady
      w = wraps;
      keys = 16'h1 << 6;
      wait_to(w + 2);
      keys = '0;
      wait_to(w + 3);
      keys = 16'h1 << 6;
      push(mk(0, 0, 0, 1, 0, 1, 4'd6), w + 6);
      wait_to(w + 7);
      keys = '0;
      push('0, w + 10);
      wait_to(w + 11);
      // multiple keys: 4+6, then add 2
      w = wraps;
      keys = (16'h1 << 4) | (16'h1 << 6);
      push(mk(0, 1, 0, 1, 0, 1, 4'd4), w + 3);
      wait_to(w + 4);
      keys = keys | (16'h1 << 1);
      push(mk(1, 1, 0, 1, 0, 1, 4'd1), w + 7);
      wait_to(w + 8);
      keys = '0;
      push('0, w + 11);
      wait_to(w + 12);
      // mid-scan reset with key 8 debounced high
      w = wraps;
      keys = 16'h1 << 9;
      push(mk(0, 0, 0, 0, 1, 1, 4'd9), w + 3);
      wait_to(w + 4);
      repeat (8) @(negedge clk);
      #1;
      chk("pre_reset_col2", int'(col_n), 4'b1011);
      chk("pre_reset_down", int'(ask_move_down), 1);
      resetN = 1'b0;
      #1;
      chk("midreset_col_n", int'(col_n), 4'b1110);
      chk("midreset_down", int'(ask_move_down), 0);
      chk("midreset_outputs", int'(out_v), 0);
      repeat (3) @(negedge clk);
      #1;
      resetN = 1'b1;
      w = wraps;
      push(mk(0, 0, 0, 0, 1, 1, 4'd9), w + 3);
      wait_to(w + 4);
      keys = '0;
      push('0, w + 7);
      wait_to(w + 8);
      // one-scan press of key 2 never reaches the outputs
      w = wraps;
      keys = 16'h1 << 1;
      wait_to(w + 1);
      keys = '0;
      wait_to(w + 5);
      chk("short_press_up", int'(ask_move_up), 0);
      chk("short_press_queue", q.size(), 0);
      // key 2 edge at the second-to-last cycle of the column-1 dwell
      w = wraps;
      repeat (6) @(negedge clk);
      #1;
      keys = 16'h1 << 1;
      push(mk(1, 0, 0, 0, 0, 1, 4'd1), w + 4);
      wait_to(w + 5);
      keys = '0;
      push('0, w + 8);
      wait_to(w + 9);
      chk("queue_drained", q.size(), 0);
      finish_run();
   end
endmodule

// File: doc/kong_keypad_scanner.md
# kong_keypad_scanner

Drives and reads the board's 4x4 matrix keypad and produces the debounced movement requests consumed by the Kong movement logic: `ask_move_right`, `ask_move_left`, `ask_move_up`, `ask_move_down` and `ask_move_jump`. It sits between the keypad pins and the game logic, and runs free of `startOfFrame`. The movement logic ORs these requests over each frame, so the outputs are steady levels, not pulses.

## Interface
- `SCAN_DIV`, default 50000: clocks each column is driven, 1 ms at 50 MHz; legal values are ≥ 4.
- `DEBOUNCE_SCANS`, default 8: consecutive full scans that must agree before a key's state changes; legal values are 1..255.
- `clk`  in  1  system clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `row_n`  in  4  keypad rows; active low; pulled up externally; asynchronous to `clk`.
- `col_n`  out  4  keypad column drive; exactly one bit is low at any time.
- `ask_move_up`  out  1  debounced key "2" (index 1).
- `ask_move_left`  out  1  debounced key "4" (index 4).
- `ask_move_jump`  out  1  debounced key "5" (index 5).
- `ask_move_right`  out  1  debounced key "6" (index 6).
- `ask_move_down`  out  1  debounced key "8" (index 9).
- `key_pressed`  out  1  any debounced key is down.
- `key_code`  out  4  lowest index among debounced pressed keys; 0 when none is pressed.

## Operation
- **Key index** = row*4 + col. The layout is row-major: "1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D".
- **Row synchronizer:** `row_n` passes through a 2-FF synchronizer, then is inverted to give active-high `row_s`.
- **Dwell counter:** runs 0..SCAN_DIV-1.
  - At SCAN_DIV-1, `row_s` is written into raw bits [col*4+r] for the active column, then the column advances 0→1→2→3→0 and the counter wraps.
  - Sampling at the end of the dwell covers synchronizer and line settling.
- **Scan boundary:** the sample of column 3 completes a scan and raises `scan_done` for one cycle.
- **Per-key debounce** (16 instances), evaluated only on `scan_done`:
  - raw == stable: counter clears to 0.
  - raw != stable and counter == DEBOUNCE_SCANS-1: stable takes the raw value and the counter clears.
  - otherwise: the counter increments.
- **Outputs** are registered from the stable vector; mapping as listed in Interface.
- `key_code` is a priority encode (lowest index wins) of the stable vector.
- **Multiple keys:** every pressed key is reported. There is no ghost-key rejection.
- **Conflicting requests:** left+right or up+down are reported as-is. Arbitration belongs to the movement logic.

## Timing
- **Reset values:**
  - `col_n` = 4'b1110 (column 0 active).
  - Dwell counter 0; raw, stable and all debounce counters 0.
  - All `ask_*` outputs, `key_pressed` and `key_code` are 0.
- **Synchronizer latency:** 2 cycles. Row changes within the last 2 cycles of a dwell are seen on the next visit to that column.
- **Press latency:** a press held steadily becomes visible in stable on the DEBOUNCE_SCANS-th `scan_done` that sees it. Outputs follow 1 cycle later.
  - Worst case from pin edge: (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles.
- **Release latency:** same rule as press.
- **Bounce:** any scan that disagrees resets that key's count. A press shorter than DEBOUNCE_SCANS scans never appears.
- **Update timing:** outputs change only the cycle after `scan_done`; all five `ask_*` outputs update together.
- **Mid-scan reset:** asserting `resetN` low mid-scan immediately returns every register to its reset value, including `col_n` = 1110. Scanning restarts from column 0 on the first clock after deassertion.
- **Overflow:** counter widths are sized for the parameter maximums, so no counter wraps.

## Structure
- The shared package `kong_pkg` gains:
  - key index constants `KEY_UP`=1, `KEY_LEFT`=4, `KEY_JUMP`=5, `KEY_RIGHT`=6, `KEY_DOWN`=9;
  - `typedef logic [3:0] key_index`.
- Sub-module `kong_key_debounce`: one key, holding the stable bit and its counter. Ports: `clk`, `resetN`, `scan_done`, `raw`, `stable`; parameter `DEBOUNCE_SCANS`. It is instantiated 16 times in a generate loop.
- The scanner owns the synchronizer, dwell counter, column drive, raw vector, output mapping and priority encoder.

## Test plan
All scenarios run with SCAN_DIV=4 and DEBOUNCE_SCANS=3.
- **Reset:** `col_n`=1110 and all outputs 0. `col_n` steps 1101, 1011, 0111 and returns to 1110 every 4 cycles, one bit low at a time.
- **Jump press:** hold key "5" (`row_n[1]` low while `col_n[1]` is low) → `ask_move_jump`=1, `key_pressed`=1, `key_code`=5 exactly 1 cycle after the 3rd `scan_done`. Release → all return to 0 after 3 further scans.
- **Bounce:** key "6" present for 2 scans, absent for 1, then steady → `ask_move_right` rises only after 3 consecutive present scans; never glitches during the bounce.
- **Multiple keys:** keys "4" and "6" held together → `ask_move_left`=`ask_move_right`=1, `key_code`=4. Add key "2" → `key_code`=1.
- **Mid-scan reset:** pull `resetN` low during column 2 while "8" is debounced high → `ask_move_down`=0 and `col_n`=1110 with no clock. "8" reappears 3 scans after release of reset.
- **Short press and late edge:** a 1-scan press of "2" → `ask_move_up` stays 0. A row edge in the last 2 cycles of the column-1 dwell is not captured until that column's next visit.
